// File: rtl/fetch_unit_pkg.sv
// Shared encodings and defaults for the instruction-fetch front end.
package fetch_unit_pkg;

  localparam int DEFAULT_WORD_SIZE = 16;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch FIFO with flush; DEPTH must be a power of two so pointers wrap naturally.
module fetch_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_pop;

  assign do_pop = pop && (count != '0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  // Slots are reserved when a request is issued, so a push can never meet a full queue.
  full_push_a: assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && count == CW'(DEPTH)));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: memory handshake, prefetch queue, redirect/flush, ID handoff.
// Optional FETCH_STATS_EN adds bubble_count and flush_count outputs.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                   WORD_SIZE   = DEFAULT_WORD_SIZE,
  parameter int                   QUEUE_DEPTH = 4,
  parameter logic [WORD_SIZE-1:0] RESET_PC    = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         i_readM,
  output logic [WORD_SIZE-1:0]         i_address,
  input  logic [WORD_SIZE-1:0]         i_data,
  input  logic                         input_ready,
  input  logic                         redirect_valid,
  input  logic [WORD_SIZE-1:0]         redirect_pc,
  output logic                         inst_valid,
  output logic [WORD_SIZE-1:0]         inst,
  output logic [WORD_SIZE-1:0]         inst_pc,
  output logic [WORD_SIZE-1:0]         inst_npc,
  input  logic                         inst_ready,
  output logic [WORD_SIZE-1:0]         num_inst,
  output logic [$clog2(QUEUE_DEPTH):0] queue_count
`ifdef FETCH_STATS_EN
  ,
  output logic [WORD_SIZE-1:0]         bubble_count,
  output logic [WORD_SIZE-1:0]         flush_count
`endif
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_e           state;
  fetch_state_e           state_next;
  logic [WORD_SIZE-1:0]   fetch_pc;
  logic [WORD_SIZE-1:0]   head_inst;
  logic [WORD_SIZE-1:0]   head_pc;
  logic [2*WORD_SIZE-1:0] head;
  logic [CW-1:0]          count_after;
  logic                   pop;
  logic                   push;
  logic                   space;

  assign pop         = inst_valid && inst_ready;
  assign push        = input_ready && (state == FETCH_WAIT) && !redirect_valid;
  assign count_after = queue_count + CW'(push) - CW'(pop);
  assign space       = count_after < CW'(QUEUE_DEPTH);

  fetch_queue #(
    .WIDTH (2 * WORD_SIZE),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({i_data, fetch_pc}),
    .pop       (pop),
    .head      (head),
    .count     (queue_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH_IDLE: if (!redirect_valid && space) state_next = FETCH_WAIT;
      FETCH_WAIT: begin
        if (redirect_valid)   state_next = input_ready ? FETCH_IDLE : FETCH_DROP;
        else if (input_ready) state_next = space ? FETCH_WAIT : FETCH_IDLE;
      end
      FETCH_DROP: if (input_ready) state_next = FETCH_IDLE;
      default:    state_next = FETCH_IDLE;
    endcase
  end

  always_comb begin
    i_readM = (state != FETCH_IDLE);
  end

  // In WAIT the outstanding address always equals fetch_pc; DROP keeps the stale one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc  <= RESET_PC;
      i_address <= RESET_PC;
      num_inst  <= '0;
    end else begin
      if (pop) num_inst <= num_inst + WORD_SIZE'(1);
      if (redirect_valid) fetch_pc <= redirect_pc;
      else if (push)      fetch_pc <= fetch_pc + WORD_SIZE'(1);
      if (state_next == FETCH_WAIT)
        i_address <= push ? fetch_pc + WORD_SIZE'(1) : fetch_pc;
    end
  end

  assign {head_inst, head_pc} = head;
  assign inst_valid = (queue_count != '0);
  assign inst       = inst_valid ? head_inst : '0;
  assign inst_pc    = inst_valid ? head_pc : '0;
  assign inst_npc   = inst_valid ? head_pc + WORD_SIZE'(1) : '0;

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_count <= '0;
      flush_count  <= '0;
    end else begin
      if (inst_ready && !inst_valid) bubble_count <= bubble_count + WORD_SIZE'(1);
      if (redirect_valid)            flush_count  <= flush_count + WORD_SIZE'(1);
    end
  end
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch front end for the pipelined TSC datapath. It replaces the fixed single-word IF latch with the following:
- a variable-latency instruction-memory handshake;
- a QUEUE_DEPTH-entry prefetch queue;
- PC redirect with flush of the queue;
- a valid/ready handoff to the ID stage.

It sits between instruction memory and the decode/IR logic, and it owns the fetch PC and the retired-fetch counter.

Parameters:
WORD_SIZE, 16, width of instruction words, addresses and PC.
QUEUE_DEPTH, 4, prefetch queue entries; power of two, ≥2.
RESET_PC, 0, fetch address after reset.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
i_readM  output  1  instruction memory read request; held until accepted.
i_address  output  WORD_SIZE  request address; stable while i_readM=1.
i_data  input  WORD_SIZE  memory response word; valid when input_ready=1.
input_ready  input  1  one-cycle response strobe for the outstanding request.
redirect_valid  input  1  branch/jump redirect from a later stage.
redirect_pc  input  WORD_SIZE  new fetch address.
inst_valid  output  1  queue head valid.
inst  output  WORD_SIZE  head instruction.
inst_pc  output  WORD_SIZE  address of the head instruction.
inst_npc  output  WORD_SIZE  inst_pc+1, wrapping modulo 2^WORD_SIZE.
inst_ready  input  1  ID accepts the head this cycle.
num_inst  output  WORD_SIZE  count of completed inst handshakes, wrapping.
queue_count  output  clog2(QUEUE_DEPTH)+1  current occupancy.

Behaviour:
Reset (asynchronous, effective immediately):
- i_readM=0, i_address=RESET_PC, fetch_pc=RESET_PC.
- Queue empty; inst_valid=0; inst, inst_pc, inst_npc = 0.
- num_inst=0, queue_count=0, state IDLE.

Request and response rules:
- At most one request outstanding.
- Addresses are word-addressed; fetch_pc increments by 1 per accepted response and wraps.
- A new request is issued (registered, next cycle) only when queue_count + outstanding < QUEUE_DEPTH.

FSM:
- IDLE: if space, assert i_readM with i_address=fetch_pc → WAIT.
- WAIT: when input_ready=1:
  - enqueue {i_data, fetch_pc} and increment fetch_pc;
  - if space remains, keep i_readM=1 with the new address (one word per cycle maximum); otherwise deassert → IDLE.
  - Zero-wait memory (input_ready in the first request cycle) is legal.
- DROP: keep i_readM and the old address asserted until input_ready. Discard that response, then → IDLE, which issues a request to the redirected fetch_pc on the next cycle.

Dequeue:
- inst_valid = (queue_count≠0).
- Head is visible combinationally from the queue registers.
- inst_valid && inst_ready pops the head and increments num_inst.
- Simultaneous enqueue and dequeue leaves queue_count unchanged.
- Enqueue into a full queue cannot occur because slots are reserved at request time; an assertion checks this.

Redirect (priority over everything):
- Same-cycle handshake: the head handshake completes and is counted before the flush.
- The queue is flushed and fetch_pc ← redirect_pc.
- Outstanding request with input_ready=0 → DROP.
- input_ready=1 in the same cycle → response discarded → IDLE.
- No outstanding request → IDLE.
- inst_valid=0 in the cycle after a redirect.
- A redirect arriving while in DROP updates fetch_pc and remains in DROP.

input_ready with no outstanding request is ignored.

Optional Feature:
Macro: FETCH_STATS_EN.
- Defined: adds outputs bubble_count (WORD_SIZE) and flush_count (WORD_SIZE), both reset to 0 and wrapping.
  - bubble_count increments each cycle with inst_ready=1 and inst_valid=0.
  - flush_count increments on each redirect_valid cycle.
- Undefined: neither port nor counter exists, and behaviour is otherwise identical.

Decomposition:
- constants.v holds:
  - FSM encodings FETCH_IDLE, FETCH_WAIT, FETCH_DROP (2-bit);
  - the default WORD_SIZE.
- Sub-module fetch_queue:
  - circular FIFO parametrised by width and depth;
  - flush input, push/pop;
  - head data and count outputs;
  - entry width 2*WORD_SIZE (instruction + PC).

Test Plan:
1. Zero-wait memory (input_ready tied to i_readM), inst_ready=1 → after reset release, inst_pc sequence 0,1,2,… one per cycle; num_inst=10 after 10 handshakes.
2. 3-cycle memory latency, inst_ready=0 → exactly QUEUE_DEPTH=4 requests (addr 0..3), then i_readM=0 and queue_count=4. Raising inst_ready drains 4 words in order, then fetching resumes at addr 4.
3. Redirect to 0x0100 while a request to 0x0005 is outstanding → i_readM stays at 0x0005 until input_ready, and that word is dropped. Next request is 0x0100, and the first inst_pc after the redirect is 0x0100.
4. redirect_valid, inst_ready, inst_valid and input_ready all high in the same cycle → num_inst increments by 1, the response is discarded, and queue_count=0 the next cycle.
5. redirect_pc=0xFFFF → inst_pc 0xFFFF with inst_npc 0x0000, followed by inst_pc 0x0000.
6. Assert reset mid-WAIT with a full queue → all outputs return to reset values asynchronously, and fetch restarts at RESET_PC after release. With FETCH_STATS_EN defined, bubble_count and flush_count also read 0.
